// File: rtl/ncl_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ncl_sink_pkg
//  Purpose  : Shared types and constants for the clocked dual-rail NCL sink.
//  Revision : 1.0  initial release
// ============================================================================
package ncl_sink_pkg;

    // Width of the captured-wavefront counter.
    localparam int WAVE_CNT_W = 16;

    // Handshake controller states.
    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,   // a_comp low, waiting for a complete DATA word
        WAIT_NULL = 2'd1,   // a_comp high, waiting for the channel to return to NULL
        STALL     = 2'd2    // a_comp high, holding the sender until the buffer frees
    } sink_state_t;

endpackage
`default_nettype wire

// File: rtl/ncl_sync_bus.sv
`default_nettype none
// ============================================================================
//  Module   : ncl_sync_bus
//  Purpose  : WIDTH-bit multi-flop synchronizer with synchronous reset.
//             Each bit is synchronized independently; there is no
//             bus-coherence guarantee, which the completion detector
//             downstream tolerates by waiting for a whole wavefront.
//  Revision : 1.0  initial release
// ============================================================================
module ncl_sync_bus #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2     // must be at least 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    // First stage samples the asynchronous pins.
    always_ff @(posedge clk) begin
        if (init) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0] <= d;
        end
    end

    // Remaining stages give metastability time to resolve.
    generate
        for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_stage
            // Shift one stage down the chain.
            always_ff @(posedge clk) begin
                if (init) begin
                    r_stage[k] <= '0;
                end else begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end
    endgenerate

    assign q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ncl_dualrail_sink.sv
`default_nettype none
// ============================================================================
//  Module   : ncl_dualrail_sink
//  Purpose  : Clocked consumer of a dual-rail NCL channel. Synchronizes both
//             rails, detects complete DATA / complete NULL wavefronts, drives
//             the four-phase completion back to the sender and presents each
//             captured word on a valid/ready interface.
//  Revision : 1.0  initial release
// ============================================================================
module ncl_dualrail_sink
    import ncl_sink_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [WIDTH-1:0]      a_rail0,
    input  logic [WIDTH-1:0]      a_rail1,
    output logic                  a_comp,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_illegal,
    output logic [WAVE_CNT_W-1:0] wave_count
);

    logic [WIDTH-1:0]      w_s0;
    logic [WIDTH-1:0]      w_s1;
    logic                  w_complete;
    logic                  w_null;
    logic                  w_illegal;
    logic                  w_buffer_free;
    logic                  w_capture;
    logic                  w_a_comp_next;
    sink_state_t           r_state;
    sink_state_t           w_state_next;
    logic                  r_a_comp;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_valid;
    logic                  r_err_illegal;
    logic [WAVE_CNT_W-1:0] r_wave_count;

    ncl_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rail0 (
        .clk  (clk),
        .init (init),
        .d    (a_rail0),
        .q    (w_s0)
    );

    ncl_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rail1 (
        .clk  (clk),
        .init (init),
        .d    (a_rail1),
        .q    (w_s1)
    );

    // Wavefront classification on the synchronized rails.
    assign w_complete    = &(w_s0 ^ w_s1);
    assign w_null        = ~|(w_s0 | w_s1);
    assign w_illegal     = |(w_s0 & w_s1);
    assign w_buffer_free = ~r_out_valid | out_ready;

    // Controller state and completion register.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state  <= WAIT_DATA;
            r_a_comp <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_a_comp <= w_a_comp_next;
        end
    end

    // Next-state, completion and capture decisions.
    always_comb begin
        w_state_next  = r_state;
        w_a_comp_next = r_a_comp;
        w_capture     = 1'b0;
        case (r_state)
            WAIT_DATA: begin
                if (w_complete && !w_illegal && w_buffer_free) begin
                    w_capture     = 1'b1;
                    w_a_comp_next = 1'b1;
                    w_state_next  = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (w_null) begin
                    w_state_next = STALL;
                end
            end
            STALL: begin
                // Backpressure point: DATA is only requested once the
                // output register can accept the next word.
                if (w_buffer_free) begin
                    w_a_comp_next = 1'b0;
                    w_state_next  = WAIT_DATA;
                end
            end
            default: begin
                w_a_comp_next = 1'b0;
                w_state_next  = WAIT_DATA;
            end
        endcase
    end

    // Output buffer, wavefront counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (init) begin
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_wave_count  <= '0;
        end else begin
            if (w_capture) begin
                r_out_data   <= w_s1;
                r_out_valid  <= 1'b1;
                r_wave_count <= r_wave_count + WAVE_CNT_W'(1);
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end
            if (w_illegal) begin
                r_err_illegal <= 1'b1;
            end
        end
    end

    assign a_comp      = r_a_comp;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign err_illegal = r_err_illegal;
    assign wave_count  = r_wave_count;

endmodule
`default_nettype wire

// File: tb/tb_ncl_dualrail_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ncl_dualrail_sink
//  Purpose  : Self-checking bench for ncl_dualrail_sink. A behavioural sender
//             drives dual-rail wavefronts; expected words come from a queue of
//             sent words and the expected count from a modulo-2^16 tally.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ncl_dualrail_sink;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             init;
    logic [WIDTH-1:0] a_rail0;
    logic [WIDTH-1:0] a_rail1;
    logic             a_comp;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             err_illegal;
    logic [15:0]      wave_count;

    int          checks;
    int          fails;
    int          exp_count;
    logic [7:0]  exp_q [$];
    bit          send_done;

    ncl_dualrail_sink #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .init        (init),
        .a_rail0     (a_rail0),
        .a_rail1     (a_rail1),
        .a_comp      (a_comp),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_illegal (err_illegal),
        .wave_count  (wave_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_data(input logic [7:0] w);
        a_rail1 = w;
        a_rail0 = ~w;
    endtask

    task automatic drive_null();
        a_rail1 = '0;
        a_rail0 = '0;
    endtask

    // Wait on negedges until a_comp reaches val; reports edges taken.
    task automatic wait_acomp(input logic val, input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (a_comp === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        init = 1'b1;
        out_ready = 1'b1;
        drive_data(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_comp, out_valid, out_data, err_illegal, wave_count} !== 27'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got comp=%b valid=%b data=%h err=%b cnt=%0d required all 0",
                         i, a_comp, out_valid, out_data, err_illegal, wave_count);
            end
        end
        init = 1'b0;
        exp_count = 0;
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (!ok || out_data !== 8'hA5 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL reset_recapture: got ok=%b data=%h cnt=%0d required data=a5 cnt=%0d",
                     ok, out_data, wave_count, exp_count);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_null: a_comp got 1 required 0 within budget");
        end
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        out_ready = 1'b1;
        drive_data(8'h3C);
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (!ok || cyc != SYNC_STAGES + 1) begin
            fails++;
            $display("FAIL single_latency: got %0d edges (ok=%b) required %0d", cyc, ok, SYNC_STAGES + 1);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL single_capture: got valid=%b data=%h cnt=%0d required valid=1 data=3c cnt=%0d",
                     out_valid, out_data, wave_count, exp_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_valid_pulse: got valid=%b required 0", out_valid);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
        checks++;
        if (!ok || cyc != SYNC_STAGES + 2) begin
            fails++;
            $display("FAIL single_null_latency: got %0d edges (ok=%b) required %0d", cyc, ok, SYNC_STAGES + 2);
        end
    endtask

    task automatic test_skewed();
        int cyc;
        int vcount;
        bit ok;
        bit early;
        logic [7:0] w;
        w = 8'($urandom);
        out_ready = 1'b1;
        early = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            a_rail1[i] = w[i];
            a_rail0[i] = ~w[i];
            @(negedge clk);
            if (a_comp !== 1'b0 || out_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            fails++;
            $display("FAIL skew_partial: got early capture required none before last bit");
        end
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        vcount = (out_valid === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) vcount++;
        end
        checks++;
        if (!ok || out_data !== w || vcount != 1 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL skew_capture: got ok=%b data=%h valid_cycles=%0d cnt=%0d required data=%h 1 cycle cnt=%0d",
                     ok, out_data, vcount, wave_count, w, exp_count);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        out_ready = 1'b0;
        drive_data(8'h11);
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (!ok || out_valid !== 1'b1 || out_data !== 8'h11) begin
            fails++;
            $display("FAIL bp_first: got ok=%b valid=%b data=%h required valid=1 data=11", ok, out_valid, out_data);
        end
        drive_null();
        repeat (8) @(negedge clk);
        checks++;
        if (a_comp !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall: got comp=%b valid=%b required comp=1 valid=1", a_comp, out_valid);
        end
        drive_data(8'h22);
        repeat (6) @(negedge clk);
        checks++;
        if (out_data !== 8'h11 || wave_count !== exp_count[15:0] || a_comp !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: got data=%h cnt=%0d comp=%b required data=11 cnt=%0d comp=1",
                     out_data, wave_count, a_comp, exp_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_comp !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got comp=%b valid=%b required comp=0 valid=0", a_comp, out_valid);
        end
        @(negedge clk);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (a_comp !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h22 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL bp_second: got comp=%b valid=%b data=%h cnt=%0d required comp=1 valid=1 data=22 cnt=%0d",
                     a_comp, out_valid, out_data, wave_count, exp_count);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
    endtask

    task automatic test_illegal();
        int cyc;
        bit ok;
        logic [7:0] w;
        w = 8'($urandom);
        out_ready = 1'b1;
        checks++;
        if (err_illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clear: got err=%b required 0", err_illegal);
        end
        drive_data(w);
        a_rail1[3] = 1'b1;
        a_rail0[3] = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (err_illegal !== 1'b1 || a_comp !== 1'b0 || out_valid !== 1'b0 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL illegal_block: got err=%b comp=%b valid=%b cnt=%0d required err=1 comp=0 valid=0 cnt=%0d",
                     err_illegal, a_comp, out_valid, wave_count, exp_count);
        end
        drive_data(w);
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (!ok || out_data !== w || err_illegal !== 1'b1 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL illegal_recover: got ok=%b data=%h err=%b cnt=%0d required data=%h err=1 cnt=%0d",
                     ok, out_data, err_illegal, wave_count, w, exp_count);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
    endtask

    task automatic test_random();
        send_done = 1'b0;
        exp_q.delete();
        fork
            begin : sender
                int cyc;
                bit ok;
                logic [7:0] w;
                for (int n = 0; n < 16; n++) begin
                    w = 8'($urandom);
                    exp_q.push_back(w);
                    drive_data(w);
                    wait_acomp(1'b1, 300, cyc, ok);
                    exp_count = (exp_count + 1) & 16'hFFFF;
                    checks++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL rand_data_ack word %0d: a_comp got 0 required 1 within budget", n);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    drive_null();
                    wait_acomp(1'b0, 300, cyc, ok);
                    checks++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL rand_null_ack word %0d: a_comp got 1 required 0 within budget", n);
                    end
                end
                send_done = 1'b1;
            end
            begin : consumer
                logic [7:0] e;
                for (int it = 0; it < 6000; it++) begin
                    if (send_done && out_valid !== 1'b1) break;
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL rand_word: got unexpected word %h required none", out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_data !== e) begin
                                fails++;
                                $display("FAIL rand_word: got %h required %h", out_data, e);
                            end
                        end
                    end
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0 || wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL rand_totals: got %0d undelivered cnt=%0d required 0 undelivered cnt=%0d",
                     exp_q.size(), wave_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        logic [7:0] w;
        w = 8'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        force dut.r_wave_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_wave_count;
        exp_count = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (wave_count !== exp_count[15:0]) begin
            fails++;
            $display("FAIL wrap_preload: got %0d required %0d", wave_count, exp_count);
        end
        drive_data(w);
        wait_acomp(1'b1, 20, cyc, ok);
        exp_count = (exp_count + 1) & 16'hFFFF;
        checks++;
        if (!ok || wave_count !== exp_count[15:0] || out_data !== w) begin
            fails++;
            $display("FAIL wrap_count: got ok=%b cnt=%0d data=%h required cnt=%0d data=%h",
                     ok, wave_count, out_data, exp_count, w);
        end
        drive_null();
        wait_acomp(1'b0, 20, cyc, ok);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        exp_count = 0;
        init      = 1'b1;
        out_ready = 1'b1;
        a_rail0   = '0;
        a_rail1   = '0;
        test_reset();
        test_single();
        test_skewed();
        test_backpressure();
        test_illegal();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ncl_dualrail_sink.md
# ncl_dualrail_sink

Clocked receiver terminating a dual-rail NCL channel such as one tapped from a ring or pipeline stage. Synchronizes both rails of every bit into the `clk` domain and detects complete DATA and complete NULL wavefronts. Drives the four-phase completion signal back to the self-timed side and presents each captured word on a valid/ready interface. It is the clocked consumer end of the dual-rail/completion protocol used by the buffer rings.

## Interface
- `WIDTH`, 8: number of dual-rail bits in the channel.
- `SYNC_STAGES`, 2: flip-flops per rail in the input synchronizer; minimum 2.
- `clk`  in  1  single clock.
- `init`  in  1  synchronous, active-high reset.
- `a_rail0`  in  WIDTH  rail 0 (FALSE) of each bit; asynchronous.
- `a_rail1`  in  WIDTH  rail 1 (TRUE) of each bit; asynchronous.
- `a_comp`  out  1  completion to the sender: 1 requests NULL, 0 requests DATA.
- `out_data`  out  WIDTH  captured word; bit i = rail1[i] at capture.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid & out_ready`.
- `err_illegal`  out  1  sticky; set when any bit is seen with both rails high.
- `wave_count`  out  16  number of DATA wavefronts captured, wraps at 2^16.

## Operation
- Every rail passes through its own `SYNC_STAGES`-deep synchronizer. All logic below uses the synchronized values `s0`/`s1` only.
- `complete` = every bit has exactly one of `s0[i]`, `s1[i]` high.
- `null` = every rail is low.
- `illegal` = any bit with `s0[i] & s1[i]`.
- FSM states: `WAIT_DATA`, `WAIT_NULL`, `STALL`.
- `WAIT_DATA` (a_comp=0):
  - On `complete & !illegal & buffer_free`: load `out_data <= s1`, set `out_valid`, set `a_comp`, increment `wave_count`, go to `WAIT_NULL`.
  - `buffer_free` = `!out_valid | out_ready`, evaluated in the same cycle.
- `WAIT_NULL` (a_comp=1): on `null`, go to `STALL`.
- `STALL` (a_comp=1): once `buffer_free`, clear `a_comp` and go to `WAIT_DATA`. This stage is where backpressure is applied: the sender is not asked for DATA until the buffer can take it.
- `out_valid` clears on `out_valid & out_ready` unless a new capture happens in the same cycle. A simultaneous consume and capture leaves `out_valid` = 1 with the new word.
- Illegal words:
  - `illegal` in any state sets `err_illegal`.
  - In `WAIT_DATA`, an illegal word is never captured; the FSM waits.
  - `err_illegal` clears only on `init`.
- Partial wavefronts (some bits DATA, some NULL) cause no action in any state.

## Timing
- Reset values: `a_comp`=0, `out_valid`=0, `out_data`=0, `err_illegal`=0, `wave_count`=0, state `WAIT_DATA`, all synchronizer flops 0.
- A rail edge at the pins is visible in `s0`/`s1` after `SYNC_STAGES` rising edges.
- `complete` seen in cycle t gives `out_valid`=1 and `a_comp`=1 in cycle t+1. Pin-to-`a_comp` latency is therefore `SYNC_STAGES`+1 cycles.
- `null` seen in cycle t with the buffer free gives `a_comp`=0 in cycle t+2 (one cycle through `STALL`).
- Minimum period per wavefront pair is 2·(`SYNC_STAGES`+1)+1 cycles plus the sender's delay.
- `init` asserted mid-operation clears everything on the next edge and drops `a_comp` to 0. A channel still holding DATA at that point is recaptured once the synchronizers refill. This is the required behaviour.

## Structure
- Shared package `ncl_sink_pkg`: state enum (`WAIT_DATA`, `WAIT_NULL`, `STALL`) and the constant `WAVE_CNT_W`=16.
- One sub-module, `ncl_sync_bus`: a parameterized `WIDTH`×`SYNC_STAGES` synchronizer with synchronous reset, instantiated once per rail bus.
- Completeness, null and illegal detection are combinational reductions in the top level.

## Test plan
- Reset: hold `init` 3 cycles with rails carrying DATA 0xA5 → all outputs 0 during reset. After release, 0xA5 is captured and `wave_count`=1.
- Single wavefront: drive DATA 0x3C, with `out_ready`=1 → `out_data`=0x3C, `out_valid` high for 1 cycle, `a_comp`=1 at `SYNC_STAGES`+1 cycles. Drive NULL → `a_comp`=0 two cycles after `null`.
- Skewed arrival: raise bits one per cycle over 8 cycles → no capture until the last bit arrives, then exactly one capture.
- Backpressure: `out_ready`=0, send 0x11 then NULL → `a_comp` stays 1 in `STALL`. Raise `out_ready` → `a_comp` falls next cycle; second DATA 0x22 is captured only after that.
- Illegal: bit 3 with both rails high in `WAIT_DATA` → `err_illegal`=1, no capture, `a_comp` stays 0. Correct the bit → capture proceeds and `err_illegal` stays 1.
- Wrap: preload 65535 captures → the next capture gives `wave_count`=0.
